// File: rtl/ctech_dsync_filter.sv
// ctech_dsync_filter: per-bit multi-flop synchroniser followed by a stability
// filter, registered edge pulses and sticky glitch flags. Bits are independent.
`timescale 1ns/1ps

module ctech_dsync_filter #(
  parameter int unsigned     WB       = 1,
  parameter int unsigned     STAGES   = 3,
  parameter int unsigned     FILT_CNT = 1,
  parameter logic [WB-1:0]   RST_VAL  = {WB{1'b0}}
) (
  input  logic          out_clk,
  input  logic          out_rst_n,
  input  logic [WB-1:0] in_data,
  input  logic [WB-1:0] glitch_clr,
  output logic [WB-1:0] out_data,
  output logic [WB-1:0] out_rise,
  output logic [WB-1:0] out_fall,
  output logic [WB-1:0] out_glitch
);

  localparam int unsigned   CW      = (FILT_CNT > 1) ? $clog2(FILT_CNT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT_CNT - 1);

  // sync_q[0] is the timing-exception anchor; nothing sits between chain flops
  logic [STAGES-1:0][WB-1:0] sync_q;
  logic [WB-1:0]             q_vec;

  logic [WB-1:0][CW-1:0]     cnt_q;
  logic [WB-1:0][CW-1:0]     cnt_d;
  logic [WB-1:0]             data_d;
  logic [WB-1:0]             rise_d;
  logic [WB-1:0]             fall_d;
  logic [WB-1:0]             glitch_d;

  assign q_vec = sync_q[STAGES-1];

  // Synchroniser chain: pure shift register per bit
  always_ff @(posedge out_clk or negedge out_rst_n) begin
    if (!out_rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], in_data};
    end
  end

  // Filter next-state: reset count on match, accept at terminal count, else count
  always_comb begin
    data_d   = out_data;
    cnt_d    = cnt_q;
    rise_d   = '0;
    fall_d   = '0;
    glitch_d = out_glitch & ~glitch_clr;
    for (int b = 0; b < int'(WB); b++) begin
      if (q_vec[b] == out_data[b]) begin
        cnt_d[b] = '0;
        // a non-zero count here means a pending change was abandoned
        if (cnt_q[b] != '0) begin
          glitch_d[b] = 1'b1;
        end
      end else if (cnt_q[b] == CNT_MAX) begin
        data_d[b] = q_vec[b];
        cnt_d[b]  = '0;
        rise_d[b] = q_vec[b];
        fall_d[b] = ~q_vec[b];
      end else begin
        cnt_d[b] = cnt_q[b] + CW'(1);
      end
    end
  end

  // Filter state and registered outputs
  always_ff @(posedge out_clk or negedge out_rst_n) begin
    if (!out_rst_n) begin
      cnt_q      <= '0;
      out_data   <= RST_VAL;
      out_rise   <= '0;
      out_fall   <= '0;
      out_glitch <= '0;
    end else begin
      cnt_q      <= cnt_d;
      out_data   <= data_d;
      out_rise   <= rise_d;
      out_fall   <= fall_d;
      out_glitch <= glitch_d;
    end
  end

endmodule
